alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes the low 32 bits of a 32x32 product by sequencing the shared 32-bit ALU through repeated ADD operations (shift-and-add).
- Sits beside the ALU in the datapath.
- While busy it asserts alu_req; the datapath steers ALU operands and control from this block instead of the decoder.
- The ALU itself is unchanged. This block only drives its Control_Line/SrcA/SrcB and reads its result.

---
 rtl/alu_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiplier that borrows the shared ALU for its ADD steps
module alu_mul_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [2:0]  ADD_CODE = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               alu_req_q, alu_req_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]   alu_src_a_q, alu_src_a_d;
  logic [WIDTH-1:0]   alu_src_b_q, alu_src_b_d;

  // Next-state and next-output logic; ALU drive is registered, so it is computed
  // from the values acc/mcand will hold in the coming RUN cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    alu_req_d   = 1'b0;
    alu_ctrl_d  = 3'b000;
    alu_src_a_d = '0;
    alu_src_b_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          acc_d       = '0;
          mcand_d     = op_a;
          mplier_d    = op_b;
          busy_d      = 1'b1;
          alu_req_d   = 1'b1;
          alu_ctrl_d  = ADD_CODE;
          alu_src_a_d = '0;
          alu_src_b_d = op_a;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (mplier_q == '0) begin
          // Multiplier exhausted: acc already holds the product.
          state_d  = S_DONE;
          result_d = acc_q;
          done_d   = 1'b1;
        end else begin
          // ALU sum is only taken when the current multiplier bit is set.
          if (mplier_q[0]) begin
            acc_d = alu_result;
          end
          mcand_d     = mcand_q << 1;
          mplier_d    = mplier_q >> 1;
          alu_req_d   = 1'b1;
          alu_ctrl_d  = ADD_CODE;
          alu_src_a_d = acc_d;
          alu_src_b_d = mcand_d;
        end
      end

      S_DONE: begin
        // start seen here is dropped; a new op needs start high again in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_req_q   <= 1'b0;
      alu_ctrl_q  <= 3'b000;
      alu_src_a_q <= '0;
      alu_src_b_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_req_q   <= alu_req_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign alu_req   = alu_req_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_src_a = alu_src_a_q;
  assign alu_src_b = alu_src_b_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - checks the multiply sequencer against an arithmetic model and literal vectors
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, alu_req;
  logic [31:0] result, alu_src_a, alu_src_b, alu_result;
  logic [2:0]  alu_ctrl;

  int checks = 0;
  int failures = 0;

  alu_mul_sequencer #(.WIDTH(32), .ADD_CODE(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result)
  );

  // Stand-in ALU: ADD for code 0, something unrelated otherwise.
  assign alu_result = (alu_ctrl == 3'b000) ? (alu_src_a + alu_src_b) : (alu_src_a ^ 32'hA5A5_5A5A);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int runs_for(input logic [31:0] b);
    if (b == 0) return 1;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
    return 1;
  endfunction

  // Model: mode 0 idle, 1 run (step k of n), 2 done.
  int          m_mode = 0;
  int          m_k = 0;
  int          m_n = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0; m_n <= 0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode <= 1; m_k <= 0; m_a <= op_a; m_b <= op_b; m_n <= runs_for(op_b);
        end
        1: if (m_k == m_n - 1) begin
          m_mode <= 2; m_res <= m_a * m_b;
        end else begin
          m_k <= m_k + 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic [63:0] mask;
    logic [31:0] exp_a, exp_b;
    mask  = (64'd1 << m_k) - 64'd1;
    exp_a = (m_mode == 1) ? m_a * (m_b & mask[31:0]) : 32'd0;
    exp_b = (m_mode == 1) ? (m_a << m_k) : 32'd0;
    check("busy", {63'd0, busy}, {63'd0, m_mode != 0});
    check("done", {63'd0, done}, {63'd0, m_mode == 2});
    check("alu_req", {63'd0, alu_req}, {63'd0, m_mode == 1});
    check("alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
    check("alu_src_a", {32'd0, alu_src_a}, {32'd0, exp_a});
    check("alu_src_b", {32'd0, alu_src_b}, {32'd0, exp_b});
    if (m_mode != 1) check("result", {32'd0, result}, {32'd0, m_res});
  end

  logic [31:0] seq [64];

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
  endtask

  task automatic wait_done(input bit hold, output int runs, output int busys);
    bit ok;
    runs = 0; busys = 0; ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (alu_req) begin
        seq[runs[5:0]] = alu_src_a;
        runs++;
      end
      if (busy) busys++;
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_runs);
    int runs, busys;
    issue(a, b);
    wait_done(1'b0, runs, busys);
    check({name, "_result"}, {32'd0, result}, {32'd0, exp_res});
    check({name, "_runs"}, runs, exp_runs);
    check({name, "_busy"}, busys, exp_runs + 1);
  endtask

  initial begin
    int runs, busys, cnt;

    // Reset held with start asserted: everything must stay zero.
    start = 1'b1; op_a = 32'd11; op_b = 32'd2;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, alu_req, alu_ctrl, alu_src_a, alu_src_b, result} == '0, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_accept", {62'd0, busy, alu_req}, 64'd3);
    wait_done(1'b0, runs, busys);
    check("rst_op_result", {32'd0, result}, 64'd22);

    // Basic 3*5 with partial-sum trace.
    issue(32'd3, 32'd5);
    wait_done(1'b0, runs, busys);
    check("basic_result", {32'd0, result}, 64'd15);
    check("basic_runs", runs, 4);
    check("basic_busy", busys, 5);
    check("basic_seq", {seq[0], seq[1], seq[2], seq[3]}, {32'd0, 32'd3, 32'd3, 32'd15});

    run_op("zero_mplier", 32'h1234, 32'd0, 32'd0, 1);
    run_op("wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    run_op("wrap_pow", 32'h0001_0000, 32'h0001_0000, 32'd0, 18);
    run_op("mix", 32'h1234_5678, 32'h0000_0A0B, 32'h1234_5678 * 32'h0000_0A0B, 13);

    // Start held through RUN and DONE; second op only after IDLE.
    issue(32'd7, 32'd6);
    wait_done(1'b1, runs, busys);
    check("b2b_first", {32'd0, result}, 64'd42);
    check("b2b_first_runs", runs, 4);
    op_a = 32'd2; op_b = 32'd9;
    @(negedge clk);
    check("b2b_gap_idle", {63'd0, busy}, 64'd0);
    check("b2b_hold", {32'd0, result}, 64'd42);
    wait_done(1'b0, runs, busys);
    check("b2b_second", {32'd0, result}, 64'd18);
    check("b2b_second_runs", runs, 5);

    // Abort in the third RUN cycle.
    issue(32'd5, 32'hFF);
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (alu_req) cnt++;
    end
    check("abort_reached", cnt, 3);
    #2 rst_n = 1'b0;
    #1 check("abort_zero", {busy, done, alu_req, alu_ctrl, alu_src_a, alu_src_b, result} == '0, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_result_zero", {32'd0, result}, 64'd0);
    run_op("after_abort", 32'd5, 32'hFF, 32'd1275, 9);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
